// File: rtl/conv_acc_rx.sv
// Receive-side MAC for conv layer 1: 9-beat windows of 16 pixel lanes x 4 kernels,
// producing 64 saturated fixed-point results per window plus window/frame position.

module conv_acc_lane #(
  parameter int bits      = 16,
  parameter int acc_bits  = 36,
  parameter int frac_bits = 8,
  parameter int relu_en   = 0
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            en,
  input  logic            first,
  input  logic [bits-1:0] pix,
  input  logic [bits-1:0] wt,
  output logic [bits-1:0] sat_out
);
  logic signed [2*bits-1:0]   prod;
  logic signed [acc_bits-1:0] prod_ext;
  logic signed [acc_bits-1:0] acc;
  logic signed [acc_bits-1:0] shifted;
  logic [acc_bits-bits:0]     upper;
  logic [bits-1:0]            sat;

  assign prod     = $signed(pix) * $signed(wt);
  assign prod_ext = {{(acc_bits-2*bits){prod[2*bits-1]}}, prod};

  // beat 0 overwrites, so a new window never needs a clear bubble
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (en)  acc <= first ? prod_ext : acc + prod_ext;
  end

  // in range only when every bit above the result MSB matches the sign
  assign shifted = acc >>> frac_bits;
  assign upper   = shifted[acc_bits-1:bits-1];

  always_comb begin
    sat = shifted[bits-1:0];
    if (!upper[acc_bits-bits] && (|upper))     sat = {1'b0, {(bits-1){1'b1}}};
    else if (upper[acc_bits-bits] && !(&upper)) sat = {1'b1, {(bits-1){1'b0}}};
    sat_out = sat;
    if ((relu_en != 0) && sat[bits-1]) sat_out = '0;
  end
endmodule

module conv_acc_rx #(
  parameter int bits            = 16,
  parameter int bits_shift      = 4,
  parameter int channel_all_num = 16,
  parameter int bits_channel    = 256,
  parameter int conv_num        = 4,
  parameter int weight_num      = 9,
  parameter int weight_num_2    = 4,
  parameter int frac_bits       = 8,
  parameter int acc_bits        = 36,
  parameter int win_per_frame   = 225,
  parameter int win_cnt_bits    = 8,
  parameter int relu_en         = 0
) (
  input  logic                                     clk_in,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     map_valid,
  input  logic [bits_channel-1:0]                  map,
  input  logic [conv_num*bits-1:0]                 weight,
  output logic [conv_num*channel_all_num*bits-1:0] result,
  output logic                                     result_valid,
  output logic [win_cnt_bits-1:0]                  win_idx,
  output logic                                     frame_done
);
  localparam logic [weight_num_2-1:0] LAST_BEAT = weight_num_2'(weight_num - 1);
  localparam logic [win_cnt_bits-1:0] LAST_WIN  = win_cnt_bits'(win_per_frame - 1);

  typedef enum logic {IDLE, ACC} state_t;
  state_t state, state_nxt;

  logic [weight_num_2-1:0] beat_cnt, beat_nxt, beat_cur;
  logic                    accept;

  logic [bits_channel-1:0]  map_r;
  logic [conv_num*bits-1:0] weight_r;
  logic [weight_num_2-1:0]  beat_r;
  // [0]: stage-1 beat valid, [1]: stage-2 holds a completed window
  logic [1:0]               vld_pipe;

  logic [conv_num*channel_all_num-1:0][bits-1:0] sat_all;
  logic [win_cnt_bits-1:0]                       win_cnt;

  assign accept   = map_valid & ~start;
  assign beat_cur = (state == IDLE) ? '0 : beat_cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    if (start) begin
      state_nxt = IDLE;
      beat_nxt  = '0;
    end else if (map_valid) begin
      if (beat_cur == LAST_BEAT) begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end else begin
        state_nxt = ACC;
        beat_nxt  = beat_cur + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      map_r    <= '0;
      weight_r <= '0;
      beat_r   <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      vld_pipe[1] <= vld_pipe[0] & ~start & (beat_r == LAST_BEAT);
      if (accept) begin
        map_r    <= map;
        weight_r <= weight;
        beat_r   <= beat_cur;
      end
    end
  end

  for (genvar c = 0; c < conv_num; c++) begin : g_conv
    for (genvar p = 0; p < channel_all_num; p++) begin : g_lane
      conv_acc_lane #(
        .bits(bits), .acc_bits(acc_bits), .frac_bits(frac_bits), .relu_en(relu_en)
      ) u_lane (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (vld_pipe[0] & ~start),
        .first  (beat_r == '0),
        .pix    (map_r[(p << bits_shift) +: bits]),
        .wt     (weight_r[(c << bits_shift) +: bits]),
        .sat_out(sat_all[c*channel_all_num + p])
      );
    end
  end

  // result and win_idx hold between pulses; start drops any in-flight window
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
      win_idx      <= '0;
      frame_done   <= 1'b0;
      win_cnt      <= '0;
    end else begin
      result_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (start) begin
        win_cnt <= '0;
        win_idx <= '0;
      end else if (vld_pipe[1]) begin
        result       <= sat_all;
        result_valid <= 1'b1;
        win_idx      <= win_cnt;
        frame_done   <= (win_cnt == LAST_WIN);
        win_cnt      <= (win_cnt == LAST_WIN) ? '0 : win_cnt + 1'b1;
      end
    end
  end
endmodule
